// File: rtl/hanoi_pkg.sv
// hanoi_pkg -- shared types and helpers for the hanoi move sequencer.
//   state_t   : sequencer states (IDLE, RUN, DONE, ERROR)
//   PEG_W     : bits per peg field (3 pegs)
//   MAX_N     : largest supported ring count
//   MAX_IND_W : ring-index width at MAX_N
//   ring_peg  : extract the peg of one ring from a packed rings vector
//               (narrower vectors are zero-extended to RINGS_MAX_W by the caller)
package hanoi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam int unsigned PEG_W       = 2;
    localparam int unsigned MAX_N       = 16;
    localparam int unsigned MAX_IND_W   = 4;
    localparam int unsigned RINGS_MAX_W = MAX_N * PEG_W;

    function automatic logic [PEG_W-1:0] ring_peg(
        input logic [RINGS_MAX_W-1:0] rings,
        input logic [MAX_IND_W-1:0]   idx
    );
        return PEG_W'(rings >> (idx * PEG_W));
    endfunction

endpackage

// File: rtl/hanoi_move_gen.sv
// hanoi_move_gen -- combinational move generator for the iterative Hanoi solve.
//   k     : in  move number (1 .. 2^N-1)
//   rings : in  current peg of every ring, ring i at [(i+1)*PEG_W-1 -: PEG_W]
//   ind   : out ring to move = trailing-zero count of k
//   loc   : out destination peg
//   legal : out (HANOI_CHECK_EN only) move is from the top of its peg and
//               lands on a peg holding no smaller ring
module hanoi_move_gen
    import hanoi_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]         k,
    input  logic [N*PEG_W-1:0]   rings,
    output logic [$clog2(N)-1:0] ind,
    output logic [PEG_W-1:0]     loc
`ifdef HANOI_CHECK_EN
    ,
    output logic                 legal
`endif
);

    localparam int unsigned IND_W  = $clog2(N);
    // Parity of the top ring's distance (N-1); rings whose distance from the
    // top is even rotate "downwards" (0->2->1->0), the others rotate upwards.
    localparam logic        TOP_ODD = logic'((N - 1) % 2);

    logic [RINGS_MAX_W-1:0] w_rings_pad;
    logic [PEG_W-1:0]       w_old;
    logic                   w_even;

    assign w_rings_pad = RINGS_MAX_W'(rings);

    // Scan from the top bit down so the lowest set bit wins.
    always_comb begin
        ind = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (k[N-1-i]) ind = IND_W'(N - 1 - i);
        end
    end

    assign w_old  = ring_peg(w_rings_pad, MAX_IND_W'(ind));
    assign w_even = (ind[0] == TOP_ODD);

    always_comb begin
        if (w_even) loc = (w_old == 2'd0) ? 2'd2 : w_old - 2'd1;
        else        loc = (w_old == 2'd2) ? 2'd0 : w_old + 2'd1;
    end

`ifdef HANOI_CHECK_EN
    always_comb begin
        legal = 1'b1;
        for (int unsigned j = 0; j < N; j++) begin
            if (j < 32'(ind)) begin
                if (ring_peg(w_rings_pad, MAX_IND_W'(j)) == w_old ||
                    ring_peg(w_rings_pad, MAX_IND_W'(j)) == loc)
                    legal = 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/hanoi_move_seq.sv
// hanoi_move_seq -- issues the optimal 2^N-1 move sequence (peg 0 -> peg 2)
// to the hanoi datapath, one move per move_valid/move_ready handshake.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   start      : begin a solve (sampled in IDLE only)
//   rings      : current peg of each ring, read back from hanoi
//   move_ready : consumer accepts the presented move
//   move_valid : ind/loc hold a valid move (high in RUN)
//   ind, loc   : ring index and destination peg (0 outside RUN)
//   busy       : high in RUN
//   done       : one-cycle pulse after the last move is accepted
//   move_count : moves accepted in the current/last solve
//   error      : illegal move seen (HANOI_CHECK_EN builds only, else 0)
// Optional macro: HANOI_CHECK_EN adds legality checking and the ERROR state,
// which is left only through rst.
module hanoi_move_seq
    import hanoi_pkg::*;
#(
    parameter int unsigned N = 3,
    parameter int unsigned M = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N*$clog2(M)-1:0] rings,
    input  logic                   move_ready,
    output logic                   move_valid,
    output logic [$clog2(N)-1:0]   ind,
    output logic [$clog2(M)-1:0]   loc,
    output logic                   busy,
    output logic                   done,
    output logic [N-1:0]           move_count,
    output logic                   error
);

    if (M != 3) begin : g_bad_m
        $error("hanoi_move_seq: M must be 3");
    end
    if (N < 2 || N > MAX_N) begin : g_bad_n
        $error("hanoi_move_seq: N must be in 2..16");
    end

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [N-1:0]           r_k;
    logic [N-1:0]           r_count;
    logic                   w_accept;
    logic [$clog2(N)-1:0]   w_ind;
    logic [PEG_W-1:0]       w_loc;
`ifdef HANOI_CHECK_EN
    logic                   w_legal;
`endif

    hanoi_move_gen #(
        .N (N)
    ) u_gen (
        .k     (r_k),
        .rings (rings),
        .ind   (w_ind),
        .loc   (w_loc)
`ifdef HANOI_CHECK_EN
        ,
        .legal (w_legal)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_nxt = RUN;
            RUN: begin
                if (move_ready) begin
                    w_accept = 1'b1;
                    if (r_k == '1) w_state_nxt = DONE;
                end
`ifdef HANOI_CHECK_EN
                // An illegal move is never accepted; it parks the sequencer.
                if (!w_legal) begin
                    w_accept    = 1'b0;
                    w_state_nxt = ERROR;
                end
`endif
            end
            DONE:    w_state_nxt = IDLE;
            ERROR:   w_state_nxt = ERROR;
            default: w_state_nxt = IDLE;
        endcase
    end

    // k stops at 2^N-1 on the final acceptance instead of wrapping to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k     <= '0;
            r_count <= '0;
        end else if (r_state == IDLE && start) begin
            r_k     <= {{(N-1){1'b0}}, 1'b1};
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + 1'b1;
            if (r_k != '1) r_k <= r_k + 1'b1;
        end
    end

    assign move_valid = (r_state == RUN);
    assign busy       = (r_state == RUN);
    assign done       = (r_state == DONE);
    assign ind        = move_valid ? w_ind : '0;
    assign loc        = move_valid ? w_loc : '0;
    assign move_count = r_count;
`ifdef HANOI_CHECK_EN
    assign error      = (r_state == ERROR);
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_hanoi_move_seq.sv
module tb_hanoi_move_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- N=3 instance with a small hanoi peg model ----------
    logic       start3, rdy3;
    logic [5:0] h3_rings, rings3, force_val;
    logic       force_en;
    logic       mv3, busy3, done3, err3;
    logic [1:0] ind3, loc3;
    logic [2:0] cnt3;

    assign rings3 = force_en ? force_val : h3_rings;

    always @(posedge clk or posedge rst) begin
        if (rst) h3_rings <= '0;
        else if (mv3 && rdy3)
            h3_rings <= (h3_rings & ~(6'b11 << (ind3 * 2))) | (6'(loc3) << (ind3 * 2));
    end

    hanoi_move_seq #(.N(3), .M(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .rings(rings3),
        .move_ready(rdy3), .move_valid(mv3), .ind(ind3), .loc(loc3),
        .busy(busy3), .done(done3), .move_count(cnt3), .error(err3)
    );

    // ---------------- N=4 instance ---------------------------------------
    logic       start4, rdy4;
    logic [7:0] h4_rings;
    logic       mv4, busy4, done4, err4;
    logic [1:0] ind4, loc4;
    logic [3:0] cnt4;
    int         done4_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) h4_rings <= '0;
        else if (mv4 && rdy4)
            h4_rings <= (h4_rings & ~(8'b11 << (ind4 * 2))) | (8'(loc4) << (ind4 * 2));
    end

    always @(negedge clk) if (done4) done4_cnt++;

    hanoi_move_seq #(.N(4), .M(3)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .rings(h4_rings),
        .move_ready(rdy4), .move_valid(mv4), .ind(ind4), .loc(loc4),
        .busy(busy4), .done(done4), .move_count(cnt4), .error(err4)
    );

    // Hand-computed optimal sequences.
    localparam int EXP3_IND [7]  = '{0, 1, 0, 2, 0, 1, 0};
    localparam int EXP3_LOC [7]  = '{2, 1, 1, 2, 0, 2, 2};
    localparam int EXP4_IND [15] = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0};
    localparam int EXP4_LOC [15] = '{1, 2, 2, 1, 0, 1, 1, 2, 2, 0, 0, 2, 1, 2, 2};

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Full N=3 solve; optional 5-cycle stall before accepting move stall_at,
    // optional stray start pulse during move restart_at (-1 disables).
    task automatic run3(input int stall_at, input int restart_at);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("n3_valid", 32'(mv3), 1);
            chk("n3_busy",  32'(busy3), 1);
            chk("n3_ind",   32'(ind3), EXP3_IND[i]);
            chk("n3_loc",   32'(loc3), EXP3_LOC[i]);
            chk("n3_count", 32'(cnt3), i);
            if (i == stall_at) begin
                rdy3 = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_valid", 32'(mv3), 1);
                    chk("stall_ind",   32'(ind3), EXP3_IND[i]);
                    chk("stall_loc",   32'(loc3), EXP3_LOC[i]);
                    chk("stall_count", 32'(cnt3), i);
                end
                rdy3 = 1'b1;
            end
            if (i == restart_at) start3 = 1'b1;
            tick();
            start3 = 1'b0;
        end
        chk("n3_done",       32'(done3), 1);
        chk("n3_done_valid", 32'(mv3), 0);
        chk("n3_done_busy",  32'(busy3), 0);
        chk("n3_done_count", 32'(cnt3), 7);
        chk("n3_rings",      32'(h3_rings), 32'h2A);
        tick();
        chk("n3_done_pulse", 32'(done3), 0);
        chk("n3_idle_valid", 32'(mv3), 0);
        chk("n3_hold_count", 32'(cnt3), 7);
    endtask

    initial begin
        rst = 1'b1; start3 = 1'b0; start4 = 1'b0; rdy3 = 1'b1; rdy4 = 1'b1;
        force_en = 1'b0; force_val = '0;
        #1;
        chk("rst_valid", 32'(mv3), 0);
        chk("rst_ind",   32'(ind3), 0);
        chk("rst_loc",   32'(loc3), 0);
        chk("rst_busy",  32'(busy3), 0);
        chk("rst_done",  32'(done3), 0);
        chk("rst_count", 32'(cnt3), 0);
        chk("rst_error", 32'(err3), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_valid", 32'(mv3), 0);

        // Plain solve, then stalled solve, then stray start during RUN.
        run3(-1, -1);
        do_reset();
        run3(3, -1);
        do_reset();
        run3(-1, 1);
        do_reset();

        // Reset in the middle of a solve.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (3) tick();
        chk("mid_count", 32'(cnt3), 3);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(mv3), 0);
        chk("midrst_ind",   32'(ind3), 0);
        chk("midrst_loc",   32'(loc3), 0);
        chk("midrst_busy",  32'(busy3), 0);
        chk("midrst_done",  32'(done3), 0);
        chk("midrst_count", 32'(cnt3), 0);
        chk("midrst_error", 32'(err3), 0);
        tick();
        rst = 1'b0;
        tick();
        run3(-1, -1);

        // N=4 solve.
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("n4_valid", 32'(mv4), 1);
            chk("n4_ind",   32'(ind4), EXP4_IND[i]);
            chk("n4_loc",   32'(loc4), EXP4_LOC[i]);
            chk("n4_count", 32'(cnt4), i);
            tick();
        end
        chk("n4_done",  32'(done4), 1);
        chk("n4_count_final", 32'(cnt4), 15);
        chk("n4_rings", 32'(h4_rings), 32'hAA);
        repeat (4) tick();
        chk("n4_done_once", 32'(done4_cnt), 1);
        chk("n4_idle_valid", 32'(mv4), 0);

`ifdef HANOI_CHECK_EN
        do_reset();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        tick();
        // Move 2 presented with ring 0 reported still on peg 0.
        force_en  = 1'b1;
        force_val = 6'b000000;
        tick();
        force_en = 1'b0;
        chk("chk_error", 32'(err3), 1);
        chk("chk_valid", 32'(mv3), 0);
        chk("chk_busy",  32'(busy3), 0);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (3) tick();
        chk("chk_error_hold", 32'(err3), 1);
        chk("chk_valid_hold", 32'(mv3), 0);
        do_reset();
        chk("chk_error_clr", 32'(err3), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hanoi_move_seq.md
Name: hanoi_move_seq

Overview:
- Hardware move sequencer for the `hanoi` datapath (N rings, 3 pegs).
- On `start`, issues the optimal 2^N-1 move sequence, one move per accepted handshake. Each move is a ring index plus a destination peg, and all rings go from peg 0 to peg 2.
- Replaces the bench-side move calculation; sits directly in front of `hanoi`'s `ind`/`loc` inputs and reads back its `rings` state.

Parameters:
- N, 3, number of rings; legal range 2..16.
- M, 3, number of pegs; must equal 3, any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a solve; sampled only in IDLE.
- rings  input  N*$clog2(M)  current peg of each ring from `hanoi`; ring i occupies bits [(i+1)*$clog2(M)-1 -: $clog2(M)]; ring 0 is the smallest.
- move_ready  input  1  consumer accepts the move this cycle.
- move_valid  output  1  `ind`/`loc` hold a valid move.
- ind  output  $clog2(N)  index of the ring to move.
- loc  output  $clog2(M)  destination peg.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the final move is accepted.
- move_count  output  N  number of moves accepted so far.
- error  output  1  illegal-move flag; tied 0 unless HANOI_CHECK_EN.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; move counter k=0. All outputs 0: move_valid, ind, loc, busy, done, move_count, error.
- IDLE:
  - start=1 → RUN with k=1 on the next edge; move_valid rises one cycle after start.
  - start=0 → stay in IDLE.
- RUN:
  - move_valid=1 and busy=1.
  - ind = number of trailing zeros of k.
  - old = peg of ring `ind` taken from `rings`; this path is combinational.
  - If (N-1-ind) is even, loc = (old==0) ? 2 : old-1. Otherwise loc = (old==2) ? 0 : old+1.
  - On move_valid & move_ready: k<=k+1 and move_count<=move_count+1.
  - If the accepted move has k==2^N-1, go to DONE.
  - While move_ready=0: k, ind and move_count hold. loc may change only if `rings` changes.
- DONE: for one cycle, done=1, move_valid=0 and busy=0; then return to IDLE. move_count holds 2^N-1 until the next start.
- Starting a new solve clears move_count to 0 on entry to RUN.
- start during RUN or DONE is ignored.
- Timing contract: `hanoi` applies the accepted move on the same edge, so `rings` is current in the cycle after acceptance. Back-to-back moves at one per cycle are legal.
- k is N bits wide. The terminal compare must prevent wrap past 2^N-1.
- The caller must reset `hanoi` to all rings on peg 0 before `start`. The sequencer does not verify the initial state.

Optional Feature:
- Macro: HANOI_CHECK_EN.
- Defined: each RUN cycle, check that ring `ind` is the top of peg `old` (no smaller ring on `old`) and that no smaller ring sits on peg `loc`.
  - On violation: go to ERROR; error=1; move_valid=0; busy=0.
  - ERROR is left only by rst. start is ignored in ERROR.
- Undefined: no check logic and no ERROR state; error is tied 0.

Decomposition:
- Package `hanoi_pkg` holds:
  - the state enum (IDLE, RUN, DONE, ERROR);
  - the width localparams for ring index and peg;
  - a `ring_peg` extraction function, shared with `hanoi` and the bench.
- One sub-module, `hanoi_move_gen`: combinational, takes (k, rings) and produces (ind, loc, legal).

Test Plan:
- N=3, move_ready=1, single start pulse:
  - moves (ind,loc) = (0,2),(1,1),(0,1),(2,2),(0,0),(1,2),(0,2);
  - final rings = 6'b101010;
  - done pulses one cycle after the 7th acceptance; move_count=7.
- N=3, move_ready=0 for 5 cycles at move 4: ind=2 and loc=2 hold, move_count=3 holds; the sequence then resumes unchanged.
- N=4: 15 moves; first move (0,1); final rings all 2; done pulses exactly once.
- rst after 3 accepted moves (hanoi also reset): all outputs 0 in the same cycle, state IDLE; a new start restarts at move 1 with (0,2).
- start pulsed again during RUN at move 2: ignored; the sequence and move_count are unaffected.
- HANOI_CHECK_EN, N=3: at move 2 the bench drives rings with ring 0 still on peg 0. Required: error=1 next cycle, move_valid=0 and held there until rst.
